stack_alu_sequencer: RTL
========================

Name: stack_alu_sequencer

Overview:
- Token-driven controller that evaluates postfix (RPN) expressions on the existing STACK_BASED_ALU.
- Accepts operand/operator/end tokens over a valid/ready handshake and issues one ALU opcode per token.
- Tracks stack depth to block underflow and overflow of the ALU stack, then pops the final value and returns it with status.
- Sits between a host/command FIFO and the ALU instance; it is the only driver of the ALU's in/opcode.

Parameters:
- N, 32, datapath width; must match the ALU's n.
- DEPTH, 8, usable ALU stack entries; sets the full threshold.
- DW, $clog2(DEPTH+1), width of the depth counter.

Ports:
- clk  in  1  rising-edge clock, shared with ALU.
- rst  in  1  synchronous, active-high reset.
- tok_valid  in  1  token offered.
- tok_ready  out  1  sequencer accepts token this cycle.
- tok_kind  in  2  00 operand, 01 add, 10 mul, 11 end.
- tok_data  in  N  operand value; ignored for other kinds.
- alu_in  out  N  to ALU in.
- alu_opcode  out  3  to ALU opcode.
- alu_out  in  N  from ALU out.
- alu_overflow  in  1  from ALU overflow.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_data  out  N  final expression value.
- res_overflow  out  1  sticky: any add/mul in the expression overflowed.
- res_err  out  1  expression aborted (underflow, full, or malformed end).
- depth  out  DW  current tracked stack depth.

Behaviour:
- ALU opcodes: 3'b100 add, 3'b101 mul, 3'b110 push, 3'b111 pop, 3'b0xx nop. The ALU executes on the edge where the opcode is presented. alu_out/alu_overflow are valid the following cycle.
- alu_opcode and alu_in are registered. alu_opcode is nop in every state except ISSUE and DRAIN.
- Reset values:
  - state=ACCEPT; depth=0.
  - res_valid, res_overflow, res_err = 0; res_data=0.
  - alu_opcode=nop; alu_in=0.
  - tok_ready=0 during the reset cycle.
- States: ACCEPT, ISSUE, WAIT, RESULT, DRAIN.
- ACCEPT: tok_ready=1; a token is taken when tok_valid&tok_ready.
  - Operand with depth<DEPTH: latch push, tok_data -> ISSUE.
  - Operand with depth==DEPTH: set res_err -> DRAIN.
  - Add/mul with depth>=2: latch op -> ISSUE.
  - Add/mul with depth<2: set res_err -> DRAIN.
  - End with depth==1: latch pop -> ISSUE.
  - End with depth!=1: set res_err -> DRAIN.
- ISSUE (1 cycle): present the latched opcode.
  - Push: depth+1 -> ACCEPT.
  - Add/mul: depth-1 -> WAIT.
  - Pop: depth-1 -> WAIT.
- WAIT (1 cycle):
  - Add/mul: res_overflow |= alu_overflow -> ACCEPT.
  - Pop: res_data<=alu_out -> RESULT.
- Latency: push 2 cycles/token; add/mul 3 cycles; end to res_valid 3 cycles.
- DRAIN: issue pop each cycle while depth>0, decrementing depth. When depth reaches 0 -> RESULT with res_data=0 and res_err=1.
- RESULT: res_valid=1, tok_ready=0, all res_* held stable.
  - On res_ready: clear res_valid, res_overflow, res_err -> ACCEPT.
  - res_ready while res_valid=0 has no effect.
- tok_ready is 0 in every state except ACCEPT, so there is no simultaneous accept/result.
- Reset mid-expression returns to reset values and depth=0. The ALU itself has no reset, so the first expression after reset relies only on tracked depth; stale ALU entries are never popped.
- depth never exceeds DEPTH and never wraps below 0; either condition is an assertion failure.

Optional Feature:
- STACK_SEQ_PERF_EN defined adds two outputs:
  - perf_expr  16 bits: count of res_valid&res_ready handshakes.
  - perf_ops  16 bits: count of ISSUE cycles.
  - Both are saturating and cleared by rst.
- Without the macro, neither port nor its logic exists.

Decomposition:
- Package stack_alu_pkg holds:
  - opcode constants OP_NOP, OP_ADD, OP_MUL, OP_PUSH, OP_POP;
  - token kind constants TK_OPND, TK_ADD, TK_MUL, TK_END;
  - the state enum.
- One sub-module, stack_seq_perf, holds the two saturating counters and is instantiated only under STACK_SEQ_PERF_EN.
- The FSM and depth tracking stay in the top.

Test Plan:
- Tokens 5, 3, add, 4, mul, end with res_ready=1 -> res_data=32, res_overflow=0, res_err=0; depth returns to 0. ALU opcode sequence is push, push, add, push, mul, pop.
- N=32, tokens 200000, 500000, mul, end -> res_overflow=1, res_err=0.
- Tokens 7, add -> res_err=1, exactly one DRAIN pop issued, res_data=0, depth=0. Next expression 2, end -> res_data=2, res_err=0.
- DEPTH=4, five operands 1..5 -> fifth token triggers res_err. Four drain pops are issued; tok_ready stays 0 until res_ready.
- Tokens 9, end with res_ready held low for 6 cycles -> res_valid, res_data=9 stable; tok_ready=0 throughout; after res_ready, tok_ready=1 next cycle.
- rst asserted in WAIT after an add -> next cycle state=ACCEPT, depth=0, res_valid=0, alu_opcode=nop.

Source files
------------

// File: rtl/stack_alu_pkg.sv
// Shared definitions for the stack ALU sequencer.
//   - ALU opcode encodings (OP_*), as decoded by the stack ALU
//   - host token kind encodings (TK_*)
//   - sequencer state enum
package stack_alu_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [1:0] TK_OPND = 2'b00;
    localparam logic [1:0] TK_ADD  = 2'b01;
    localparam logic [1:0] TK_MUL  = 2'b10;
    localparam logic [1:0] TK_END  = 2'b11;

    typedef enum logic [2:0] {
        ACCEPT,
        ISSUE,
        WAIT,
        RESULT,
        DRAIN
    } state_t;

endpackage

// File: rtl/stack_seq_perf.sv
// Saturating performance counters for the stack ALU sequencer.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   expr_inc        one result handshake this cycle
//   ops_inc         one ISSUE cycle this cycle
//   perf_expr       saturating count of result handshakes
//   perf_ops        saturating count of ISSUE cycles
module stack_seq_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        expr_inc,
    input  logic        ops_inc,
    output logic [15:0] perf_expr,
    output logic [15:0] perf_ops
);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_expr <= '0;
            perf_ops  <= '0;
        end else begin
            // Counters stick at all-ones rather than wrapping.
            if (expr_inc && perf_expr != '1) perf_expr <= perf_expr + 16'd1;
            if (ops_inc  && perf_ops  != '1) perf_ops  <= perf_ops  + 16'd1;
        end
    end

endmodule

// File: rtl/stack_alu_sequencer.sv
// Token-driven RPN evaluator that drives a stack ALU.
// Accepts operand/add/mul/end tokens, issues one ALU opcode per token,
// tracks stack depth to block underflow/overflow, and returns the final
// popped value with sticky overflow and error status.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   tok_valid/ready/kind/data   token input handshake
//   alu_in, alu_opcode          registered drive to the ALU
//   alu_out, alu_overflow       ALU results, valid the cycle after an op
//   res_valid/ready/data        result handshake and value
//   res_overflow, res_err       sticky overflow, expression aborted
//   depth                       tracked ALU stack depth
// Optional: define STACK_SEQ_PERF_EN to add perf_expr / perf_ops counters.
module stack_alu_sequencer
    import stack_alu_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 8,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tok_valid,
    output logic          tok_ready,
    input  logic [1:0]    tok_kind,
    input  logic [N-1:0]  tok_data,
    output logic [N-1:0]  alu_in,
    output logic [2:0]    alu_opcode,
    input  logic [N-1:0]  alu_out,
    input  logic          alu_overflow,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_data,
    output logic          res_overflow,
    output logic          res_err,
    output logic [DW-1:0] depth
`ifdef STACK_SEQ_PERF_EN
    ,
    output logic [15:0]   perf_expr,
    output logic [15:0]   perf_ops
`endif
);

    state_t        state, state_d;
    logic [DW-1:0] depth_d;
    logic [2:0]    op_q, op_d;
    logic [2:0]    opcode_d;
    logic [N-1:0]  alu_in_d, res_data_d;
    logic          res_overflow_d, res_err_d;
    logic          depth_dec;

    assign tok_ready = (state == ACCEPT) && !rst;
    assign res_valid = (state == RESULT);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d        = state;
        depth_d        = depth;
        op_d           = op_q;
        alu_in_d       = alu_in;
        res_data_d     = res_data;
        res_overflow_d = res_overflow;
        res_err_d      = res_err;
        depth_dec      = 1'b0;
        opcode_d       = OP_NOP;

        case (state)
            ACCEPT: begin
                if (tok_valid) begin
                    case (tok_kind)
                        TK_OPND: begin
                            if (depth < DW'(DEPTH)) begin
                                op_d     = OP_PUSH;
                                alu_in_d = tok_data;
                                state_d  = ISSUE;
                            end else begin
                                res_err_d = 1'b1;
                                state_d   = DRAIN;
                            end
                        end
                        TK_ADD, TK_MUL: begin
                            if (depth >= DW'(2)) begin
                                op_d    = (tok_kind == TK_ADD) ? OP_ADD : OP_MUL;
                                state_d = ISSUE;
                            end else begin
                                res_err_d = 1'b1;
                                state_d   = DRAIN;
                            end
                        end
                        default: begin // TK_END
                            if (depth == DW'(1)) begin
                                op_d    = OP_POP;
                                state_d = ISSUE;
                            end else begin
                                res_err_d = 1'b1;
                                state_d   = DRAIN;
                            end
                        end
                    endcase
                end
            end
            ISSUE: begin
                if (op_q == OP_PUSH) begin
                    depth_d = depth + DW'(1);
                    state_d = ACCEPT;
                end else begin
                    depth_dec = 1'b1;
                    depth_d   = depth - DW'(1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (op_q == OP_POP) begin
                    res_data_d = alu_out;
                    state_d    = RESULT;
                end else begin
                    res_overflow_d = res_overflow | alu_overflow;
                    state_d        = ACCEPT;
                end
            end
            DRAIN: begin
                // A pop is on the ALU this cycle whenever depth is nonzero;
                // leave once the last entry has been removed.
                if (depth != '0) begin
                    depth_dec = 1'b1;
                    depth_d   = depth - DW'(1);
                end
                if (depth <= DW'(1)) begin
                    res_data_d = '0;
                    state_d    = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    res_overflow_d = 1'b0;
                    res_err_d      = 1'b0;
                    state_d        = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase

        // alu_opcode is registered, so it is chosen from the state being
        // entered: the op lands on the ALU during ISSUE/DRAIN itself.
        if (state_d == ISSUE) begin
            opcode_d = op_d;
        end else if (state_d == DRAIN && depth_d != '0) begin
            opcode_d = OP_POP;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state        <= ACCEPT;
            depth        <= '0;
            op_q         <= OP_NOP;
            alu_opcode   <= OP_NOP;
            alu_in       <= '0;
            res_data     <= '0;
            res_overflow <= 1'b0;
            res_err      <= 1'b0;
        end else begin
            state        <= state_d;
            depth        <= depth_d;
            op_q         <= op_d;
            alu_opcode   <= opcode_d;
            alu_in       <= alu_in_d;
            res_data     <= res_data_d;
            res_overflow <= res_overflow_d;
            res_err      <= res_err_d;
        end
    end

    a_depth_max: assert property (@(posedge clk) disable iff (rst)
        depth <= DW'(DEPTH));
    a_depth_min: assert property (@(posedge clk) disable iff (rst)
        !(depth_dec && depth == '0));

`ifdef STACK_SEQ_PERF_EN
    stack_seq_perf u_perf (
        .clk       (clk),
        .rst       (rst),
        .expr_inc  (res_valid && res_ready),
        .ops_inc   (state == ISSUE),
        .perf_expr (perf_expr),
        .perf_ops  (perf_ops)
    );
`endif

endmodule
